sub_serial: RTL and testbench

SUB_SERIAL -- requirements
Module: sub_serial

---
 rtl/sub_pkg.sv | 13 +
 rtl/sub_slice.sv | 17 +
 rtl/sub_serial.sv | 144 ++++++++++++++
 tb/tb_sub_serial.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: controller states and default sizing.
package sub_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SLICE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub_slice.sv
// One SLICE-bit subtract step, computed as a + ~b + cin; cout=1 means no borrow out.
module sub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] sum_o,
  output logic             cout_o
);

  logic [SLICE:0] total;

  assign total           = {1'b0, a_i} + {1'b0, ~b_i} + {{SLICE{1'b0}}, cin_i};
  assign {cout_o, sum_o} = total;

endmodule

// File: rtl/sub_serial.sv
// Multi-cycle subtractor: one SLICE-wide step per cycle through a single sub_slice,
// with a valid/ready handshake on both sides and one operation in flight.
module sub_serial
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = $clog2(NSLICE + 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [WIDTH-1:0]     diff_q, diff_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 carry_q, carry_d;
  logic                 a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic                 borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [SLICE-1:0]       slice_sum;
  logic                   slice_cout;
  logic [WIDTH+SLICE-1:0] res_shift;

  // Operands shift right each step, so the active slice is always the low SLICE bits.
  sub_slice #(.SLICE(SLICE)) u_slice (
    .a_i    (a_q[SLICE-1:0]),
    .b_i    (b_q[SLICE-1:0]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  assign res_shift = {slice_sum, res_q};

  always_comb begin
    // NOTE: every signal gets its default first so no path through the case infers a latch.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    diff_d    = diff_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    borrow_d  = borrow_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          res_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b1;
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (cnt_q == CW'(NSLICE)) begin
          // Closing cycle: all slices are stored, register the result and its flags.
          diff_d   = res_q;
          borrow_d = ~carry_q;
          ovf_d    = (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
          zero_d   = ~|res_q;
          state_d  = DONE;
        end else begin
          a_d     = a_q >> SLICE;
          b_d     = b_q >> SLICE;
          res_d   = res_shift[WIDTH+SLICE-1:SLICE];
          carry_d = slice_cout;
          cnt_d   = cnt_q + CW'(1);
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial: the driver queues expected results on acceptance,
// a negedge monitor pops and checks each presented result, its latency and its hold.
module tb_sub_serial;

  typedef struct {
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        borrow, ovf, zero;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rdy_mode = 0;
  bit rdy_force = 1'b1;

  exp_t exp_q[$];
  exp_t cur;
  bit   active  = 1'b0;
  bit   prev_hs = 1'b0;

  sub_serial #(.WIDTH(32), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic bo, input logic ov, input logic z);
    exp_t e;
    e.diff = d; e.borrow = bo; e.ovf = ov; e.zero = z; e.acc = 0;
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    e.diff   = av - bv;
    e.borrow = (av < bv);
    e.ovf    = (av[31] != bv[31]) && (e.diff[31] != av[31]);
    e.zero   = (e.diff == 32'd0);
    e.acc    = 0;
    return e;
  endfunction

  // Back-pressure driver: forced level, always ready, or random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = rdy_force;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops on the first cycle a result is presented, then checks it every held cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      active  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) check("out_valid_drop", 64'(out_valid), 64'd0);
      prev_hs = 1'b0;
      if (out_valid) begin
        if (!active) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
          end else begin
            cur    = exp_q.pop_front();
            active = 1'b1;
            check("latency", 64'(cyc - cur.acc), 64'd9);
          end
        end
        if (active) begin
          check("diff", 64'(diff), 64'(cur.diff));
          check("borrow", 64'(borrow), 64'(cur.borrow));
          check("ovf", 64'(ovf), 64'(cur.ovf));
          check("zero", 64'(zero), 64'(cur.zero));
          check("in_ready_done", 64'(in_ready), 64'd0);
          if (out_ready) begin
            active  = 1'b0;
            prev_hs = 1'b1;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input exp_t e);
    int   n;
    exp_t q;
    @(posedge clk);
    #1;
    a = av; b = bv; in_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 64'd1, 64'd0);
        in_valid = 1'b0;
        return;
      end
    end
    q     = e;
    q.acc = cyc + 1;
    exp_q.push_back(q);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || active) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 64'd1, 64'd0);
  endtask

  logic [31:0] dir_a [10];
  logic [31:0] dir_b [10];
  exp_t        dir_e [10];

  initial begin
    int n;
    logic [31:0] ra, rb;

    dir_a[0] = 32'h0000000A; dir_b[0] = 32'h00000003; dir_e[0] = mk(32'h00000007, 0, 0, 0);
    dir_a[1] = 32'h00000003; dir_b[1] = 32'h00000004; dir_e[1] = mk(32'hFFFFFFFF, 1, 0, 0);
    dir_a[2] = 32'h80000000; dir_b[2] = 32'h00000001; dir_e[2] = mk(32'h7FFFFFFF, 0, 1, 0);
    dir_a[3] = 32'h12345678; dir_b[3] = 32'h12345678; dir_e[3] = mk(32'h00000000, 0, 0, 1);
    dir_a[4] = 32'h00000000; dir_b[4] = 32'h00000000; dir_e[4] = mk(32'h00000000, 0, 0, 1);
    dir_a[5] = 32'h00000000; dir_b[5] = 32'h00000001; dir_e[5] = mk(32'hFFFFFFFF, 1, 0, 0);
    dir_a[6] = 32'h7FFFFFFF; dir_b[6] = 32'hFFFFFFFF; dir_e[6] = mk(32'h80000000, 1, 1, 0);
    dir_a[7] = 32'hFFFFFFFF; dir_b[7] = 32'h7FFFFFFF; dir_e[7] = mk(32'h80000000, 0, 0, 0);
    dir_a[8] = 32'h00000010; dir_b[8] = 32'h00000001; dir_e[8] = mk(32'h0000000F, 0, 0, 0);
    dir_a[9] = 32'h00000000; dir_b[9] = 32'h80000000; dir_e[9] = mk(32'h80000000, 1, 1, 0);

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    rdy_mode = 0; rdy_force = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_diff", 64'(diff), 64'd0);
    check("rst_borrow", 64'(borrow), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    rdy_mode = 1;
    for (int i = 0; i < 10; i++) begin
      send(dir_a[i], dir_b[i], dir_e[i]);
      wait_drain();
    end

    // Hold the result in DONE for several cycles before accepting it.
    rdy_mode = 0; rdy_force = 1'b0;
    send(32'hFFFFFFFF, 32'h7FFFFFFF, dir_e[7]);
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) check("hold_wait_timeout", 64'd1, 64'd0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rdy_force = 1'b1;
    wait_drain();

    // Abandon an operation with reset partway through BUSY.
    rdy_mode = 1;
    send(32'hDEADBEEF, 32'h00000001, mk(32'hDEADBEEE, 0, 0, 0));
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    send(32'd5, 32'd2, mk(32'd3, 0, 0, 0));
    wait_drain();

    // Back-to-back stream with random back-pressure against the reference model.
    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 50 == 0) rb = ra;
      if (i % 50 == 1) ra = 32'h80000000;
      send(ra, rb, model(ra, rb));
    end
    wait_drain();
    repeat (20) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
